// File: rtl/xor_seq_arbiter_pkg.sv
// Shared types and helpers for the serial XOR sequencer/arbiter.
package xor_seq_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // Single 2-input NAND; the XOR cell is composed only from these.
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  // Round-robin pick: a sole requester wins, a tie goes to the one not served last.
  function automatic owner_e pick_winner(input logic req_a, input logic req_b,
                                         input owner_e last_served);
    owner_e win;
    if (req_a && req_b) begin
      if (last_served == OWN_A) begin
        win = OWN_B;
      end else begin
        win = OWN_A;
      end
    end else if (req_a) begin
      win = OWN_A;
    end else begin
      win = OWN_B;
    end
    return win;
  endfunction

endpackage

// File: rtl/xor_seq_arbiter_cell.sv
// One-bit XOR built from five 2-input NANDs: s = (a & ~b) | (~a & b).
module xor_nand_cell
  import xor_seq_arbiter_pkg::*;
(
  output logic s,
  input  logic a,
  input  logic b
);

  logic na_s;
  logic nb_s;
  logic a_nb_s;
  logic na_b_s;

  assign na_s   = nand2(a, a);
  assign nb_s   = nand2(b, b);
  assign a_nb_s = nand2(a, nb_s);
  assign na_b_s = nand2(na_s, b);
  assign s      = nand2(a_nb_s, na_b_s);

endmodule

// File: rtl/xor_seq_arbiter.sv
// Two-requester round-robin sequencer feeding one shared NAND XOR cell,
// LSB first, one bit per clock.
module xor_seq_arbiter
  import xor_seq_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] y_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] x_b,
  input  logic [WIDTH-1:0] y_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] s,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q;
  owner_e             owner_q;
  owner_e             last_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   s_q;
  logic               gnt_a_q;
  logic               gnt_b_q;
  logic               done_a_q;
  logic               done_b_q;
  logic               busy_q;

  owner_e             win_s;
  logic               cell_s;
  logic [WIDTH-1:0]   res_shift_s;

  // Arbitration decision for the current cycle's requests.
  always_comb begin
    win_s = pick_winner(req_a, req_b, last_q);
  end

  xor_nand_cell u_cell (
    .s (cell_s),
    .a (x_q[0]),
    .b (y_q[0])
  );

  // Cell output enters at the MSB so bit 0 lands at the LSB after WIDTH shifts;
  // the concatenate-and-shift form also covers WIDTH=1 without a degenerate slice.
  assign res_shift_s = WIDTH'({cell_s, res_q} >> 1);

  // Sequencer FSM: grant and operand capture, serial XOR, completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_A;
      last_q   <= OWN_B;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      s_q      <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_a || req_b) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            owner_q <= win_s;
            count_q <= '0;
            gnt_a_q <= (win_s == OWN_A);
            gnt_b_q <= (win_s == OWN_B);
            if (win_s == OWN_A) begin
              x_q <= x_a;
              y_q <= y_a;
            end else begin
              x_q <= x_b;
              y_q <= y_b;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        BUSY: begin
          res_q <= res_shift_s;
          x_q   <= x_q >> 1;
          y_q   <= y_q >> 1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q  <= DONE;
            s_q      <= res_shift_s;
            done_a_q <= (owner_q == OWN_A);
            done_b_q <= (owner_q == OWN_B);
            last_q   <= owner_q;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign done_a = done_a_q;
  assign done_b = done_b_q;
  assign s      = s_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_xor_seq_arbiter.sv
// Self-checking bench: directed steps, scoreboard of expected results
// popped on every done pulse, for a WIDTH=8 and a WIDTH=2 instance.
module tb_xor_seq_arbiter;

  typedef struct packed {
    logic        own;
    logic [31:0] val;
  } exp_t;

  localparam logic ME_A = 1'b0;
  localparam logic ME_B = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_a, req_b;
  logic [7:0] x_a, y_a, x_b, y_b;
  logic       gnt_a, gnt_b, done_a, done_b, busy;
  logic [7:0] s;

  logic       req_a2, req_b2;
  logic [1:0] x_a2, y_a2, x_b2, y_b2;
  logic       gnt_a2, gnt_b2, done_a2, done_b2, busy2;
  logic [1:0] s2;

  int   checks = 0;
  int   errors = 0;
  int   gnt_b_seen = 0;
  int   lat;
  int   bc;
  int   dlat;
  exp_t exp8[$];
  exp_t exp2[$];
  exp_t e8;
  exp_t e2;

  xor_seq_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .x_a(x_a), .y_a(y_a),
    .req_b(req_b), .x_b(x_b), .y_b(y_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .s(s), .busy(busy)
  );

  xor_seq_arbiter #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_a(req_a2), .x_a(x_a2), .y_a(y_a2),
    .req_b(req_b2), .x_b(x_b2), .y_b(y_b2),
    .gnt_a(gnt_a2), .gnt_b(gnt_b2), .done_a(done_a2), .done_b(done_b2),
    .s(s2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return gnt_a;
      1:       return gnt_b;
      2:       return done_a;
      3:       return done_b;
      4:       return ~busy;
      5:       return gnt_a2;
      6:       return gnt_b2;
      7:       return ~busy2;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) for a selected event; lat = number of negedges waited.
  task automatic wait_for(input string tag, input int sel, input int budget, output int lat_o);
    logic hit;
    hit   = 1'b0;
    lat_o = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (sel_sig(sel)) begin
        hit   = 1'b1;
        lat_o = i;
        break;
      end
    end
    check({tag, "_in_time"}, 32'(hit), 32'd1);
  endtask

  // Scoreboard for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (gnt_b) gnt_b_seen++;
    if (done_a || done_b) begin
      if (exp8.size() == 0) begin
        check("unexpected_done8", 32'(done_a | done_b), 32'd0);
      end else begin
        e8 = exp8.pop_front();
        check("owner8", 32'(done_b), 32'(e8.own));
        check("s8", 32'(s), e8.val);
        check("done_excl8", 32'(done_a & done_b), 32'd0);
      end
    end
  end

  // Scoreboard for the WIDTH=2 instance.
  always @(negedge clk) begin
    if (done_a2 || done_b2) begin
      if (exp2.size() == 0) begin
        check("unexpected_done2", 32'(done_a2 | done_b2), 32'd0);
      end else begin
        e2 = exp2.pop_front();
        check("owner2", 32'(done_b2), 32'(e2.own));
        check("s2", 32'(s2), e2.val);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; x_a = 8'h00; y_a = 8'h00; x_b = 8'h00; y_b = 8'h00;
    req_a2 = 1'b0; req_b2 = 1'b0; x_a2 = 2'd0; y_a2 = 2'd0; x_b2 = 2'd0; y_b2 = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    check("rst_done", 32'({done_a, done_b}), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_all2", 32'({gnt_a2, gnt_b2, done_a2, done_b2, busy2, s2}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single A request: latency, pulse width, busy duration.
    req_a = 1'b1; x_a = 8'hA5; y_a = 8'h0F;
    exp8.push_back('{ME_A, 32'h0000_00AA});
    wait_for("t1_gnt_a", 0, 4, lat);
    check("t1_gnt_lat", 32'(lat), 32'd1);
    check("t1_gnt_b_low", 32'(gnt_b), 32'd0);
    req_a = 1'b0;
    bc = 1; dlat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check("t1_gnt_pulse", 32'(gnt_a), 32'd0);
      if (done_a) dlat = i + 1;
      if (!busy) break;
      bc++;
    end
    check("t1_done_lat", 32'(dlat), 32'd8);
    check("t1_busy_cycles", 32'(bc), 32'd9);

    // Both requesting from reset: A, B, A with WIDTH+2 spacing.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req_a = 1'b1; x_a = 8'h3C; y_a = 8'h3C;
    req_b = 1'b1; x_b = 8'hFF; y_b = 8'h00;
    exp8.push_back('{ME_A, 32'h0000_0000});
    exp8.push_back('{ME_B, 32'h0000_00FF});
    exp8.push_back('{ME_A, 32'h0000_0000});
    wait_for("t2_gnt_a1", 0, 4, lat);
    check("t2_gnt_a1_lat", 32'(lat), 32'd1);
    check("t2_no_gnt_b", 32'(gnt_b), 32'd0);
    wait_for("t2_gnt_b", 1, 15, lat);
    check("t2_gnt_b_gap", 32'(lat), 32'd10);
    wait_for("t2_gnt_a2", 0, 15, lat);
    check("t2_gnt_a2_gap", 32'(lat), 32'd10);
    req_a = 1'b0; req_b = 1'b0;
    wait_for("t2_idle", 4, 15, lat);

    // Request during BUSY is dropped.
    req_a = 1'b1; x_a = 8'h5A; y_a = 8'hC3;
    exp8.push_back('{ME_A, 32'h0000_0099});
    wait_for("t4_gnt_a", 0, 4, lat);
    req_a = 1'b0;
    gnt_b_seen = 0;
    repeat (3) @(negedge clk);
    req_b = 1'b1; x_b = 8'h12; y_b = 8'h34;
    @(negedge clk);
    req_b = 1'b0;
    wait_for("t4_idle", 4, 15, lat);
    check("t4_gnt_b_never", 32'(gnt_b_seen), 32'd0);

    // Operand change after grant has no effect; s held across new grant.
    req_a = 1'b1; x_a = 8'h01; y_a = 8'h00;
    exp8.push_back('{ME_A, 32'h0000_0001});
    wait_for("t3_gnt_a", 0, 4, lat);
    check("t3_s_held_at_gnt", 32'(s), 32'h99);
    req_a = 1'b0;
    @(negedge clk);
    x_a = 8'hFF;
    wait_for("t3_idle", 4, 15, lat);

    // Reset mid-operation at count=3.
    req_a = 1'b1; x_a = 8'h6B; y_a = 8'h2D;
    exp8.push_back('{ME_A, 32'h0000_0046});
    wait_for("t5_gnt_a", 0, 4, lat);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
    check("t5_rst_done", 32'({done_a, done_b}), 32'd0);
    check("t5_rst_s", 32'(s), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    exp8.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    req_a = 1'b1; x_a = 8'hE7; y_a = 8'h18;
    exp8.push_back('{ME_A, 32'h0000_00FF});
    wait_for("t5_gnt_a2", 0, 4, lat);
    req_a = 1'b0;
    wait_for("t5_done_a", 2, 12, lat);
    check("t5_done_lat", 32'(lat), 32'd8);
    wait_for("t5_idle", 4, 15, lat);
    repeat (3) @(negedge clk);
    check("t5_s_hold", 32'(s), 32'hFF);

    // Exhaustive WIDTH=2, alternating requesters.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      if (i % 2 == 0) begin
        req_a2 = 1'b1; x_a2 = v[3:2]; y_a2 = v[1:0];
        exp2.push_back('{ME_A, 32'(v[3:2] ^ v[1:0])});
        wait_for("w2_gnt_a", 5, 4, lat);
        req_a2 = 1'b0;
      end else begin
        req_b2 = 1'b1; x_b2 = v[3:2]; y_b2 = v[1:0];
        exp2.push_back('{ME_B, 32'(v[3:2] ^ v[1:0])});
        wait_for("w2_gnt_b", 6, 4, lat);
        req_b2 = 1'b0;
      end
      wait_for("w2_idle", 7, 8, lat);
    end

    check("q8_drained", 32'(exp8.size()), 32'd0);
    check("q2_drained", 32'(exp2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
